// File: rtl/ibex_pkg.sv
// ibex_pkg: shared CHERI checker constants for the fault tracker.
// Holds the checker exception-vector width, violation bit indices,
// the 5-bit CHERI cause codes and the fault-tracker FSM state enum.
package ibex_pkg;

  // Checker exception vector: one bit per violation class
  localparam int unsigned CheriExcWidth = 6;

  localparam int unsigned CHERI_TAG_VIOLATION            = 0;
  localparam int unsigned CHERI_SEAL_VIOLATION           = 1;
  localparam int unsigned CHERI_PERMIT_EXECUTE_VIOLATION = 2;
  localparam int unsigned CHERI_PERMIT_LOAD_VIOLATION    = 3;
  localparam int unsigned CHERI_PERMIT_STORE_VIOLATION   = 4;
  localparam int unsigned CHERI_LENGTH_VIOLATION         = 5;

  // CHERI cause codes reported to the controller
  localparam logic [4:0] CHERI_CAUSE_NONE           = 5'h00;
  localparam logic [4:0] CHERI_CAUSE_LENGTH         = 5'h01;
  localparam logic [4:0] CHERI_CAUSE_TAG            = 5'h02;
  localparam logic [4:0] CHERI_CAUSE_SEAL           = 5'h03;
  localparam logic [4:0] CHERI_CAUSE_PERMIT_EXECUTE = 5'h11;
  localparam logic [4:0] CHERI_CAUSE_PERMIT_LOAD    = 5'h12;
  localparam logic [4:0] CHERI_CAUSE_PERMIT_STORE   = 5'h13;

  typedef enum logic [1:0] {
    CFT_IDLE    = 2'd0,
    CFT_ACCESS  = 2'd1,
    CFT_PENDING = 2'd2
  } cheri_ft_state_e;

endpackage

// File: rtl/ibex_cheri_cause_enc.sv
// ibex_cheri_cause_enc: priority encoder, checker exception vector -> cause code.
// Purely combinational, zero latency; no flow control.
// Ports: exc_i (violation vector), cause_o (5-bit cause, 0 when no bit set).
// Priority: TAG > SEAL > PERMIT_EXECUTE > PERMIT_LOAD > PERMIT_STORE > LENGTH.
module ibex_cheri_cause_enc
  import ibex_pkg::*;
(
  input  logic [CheriExcWidth-1:0] exc_i,
  output logic [4:0]               cause_o
);

  always_comb begin
    cause_o = CHERI_CAUSE_NONE;
    if (exc_i[CHERI_TAG_VIOLATION]) begin
      cause_o = CHERI_CAUSE_TAG;
    end else if (exc_i[CHERI_SEAL_VIOLATION]) begin
      cause_o = CHERI_CAUSE_SEAL;
    end else if (exc_i[CHERI_PERMIT_EXECUTE_VIOLATION]) begin
      cause_o = CHERI_CAUSE_PERMIT_EXECUTE;
    end else if (exc_i[CHERI_PERMIT_LOAD_VIOLATION]) begin
      cause_o = CHERI_CAUSE_PERMIT_LOAD;
    end else if (exc_i[CHERI_PERMIT_STORE_VIOLATION]) begin
      cause_o = CHERI_CAUSE_PERMIT_STORE;
    end else if (exc_i[CHERI_LENGTH_VIOLATION]) begin
      cause_o = CHERI_CAUSE_LENGTH;
    end
  end

endmodule

// File: rtl/ibex_cheri_fault_tracker.sv
// ibex_cheri_fault_tracker: accumulates CHERI checker faults across the
// responses of one memory access and reports one prioritised fault.
// Latency: fault visible the cycle after the last response; stalls new
// accesses (access_ready_o=0) while a fault waits for fault_ack_i.
// Ports: access_start/rvalid/last + cheri_mem_exc/addr/auth_reg in;
//        fault_valid/cause/reg/addr out; fault_ack and flush control.
// Optional: CHERI_FAULT_COUNT_EN adds fault_count_o (saturating fault count).
module ibex_cheri_fault_tracker
  import ibex_pkg::*;
#(
  parameter bit DataMem = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     access_start_i,
  input  logic                     access_rvalid_i,
  input  logic                     access_last_i,
  input  logic [CheriExcWidth-1:0] cheri_mem_exc_i,
  input  logic                     instr_upper_exc_i,
  input  logic                     instr_compressed_i,
  input  logic [31:0]              addr_i,
  input  logic [4:0]               auth_reg_i,
  input  logic                     fault_ack_i,
  input  logic                     flush_i,
  output logic                     access_ready_o,
  output logic                     fault_valid_o,
  output logic [4:0]               fault_cause_o,
  output logic [5:0]               fault_reg_o,
  output logic [31:0]              fault_addr_o
`ifdef CHERI_FAULT_COUNT_EN
  ,
  output logic [15:0]              fault_count_o
`endif
);

  cheri_ft_state_e            r_state;
  cheri_ft_state_e            w_state_nxt;
  logic [CheriExcWidth-1:0]   r_acc;
  logic [4:0]                 r_auth_reg;
  logic [31:0]                r_fault_addr;

  logic                       w_upper_fault;
  logic [CheriExcWidth-1:0]   w_exc_eff;
  logic [CheriExcWidth-1:0]   w_acc_upd;
  logic                       w_rsp;
  logic                       w_pending;
  logic [4:0]                 w_cause;

  // A 32-bit fetch whose upper halfword is out of bounds is a length fault
  // located at the upper halfword, hence the +2 on the captured address.
  assign w_upper_fault = !DataMem && instr_upper_exc_i && !instr_compressed_i;

  always_comb begin
    w_exc_eff = cheri_mem_exc_i;
    if (w_upper_fault) begin
      w_exc_eff[CHERI_LENGTH_VIOLATION] = 1'b1;
    end
  end

  assign w_acc_upd = r_acc | w_exc_eff;
  assign w_rsp     = (r_state == CFT_ACCESS) && access_rvalid_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CFT_IDLE:    if (access_start_i) w_state_nxt = CFT_ACCESS;
      CFT_ACCESS:  if (w_rsp && access_last_i) begin
                     w_state_nxt = (|w_acc_upd) ? CFT_PENDING : CFT_IDLE;
                   end
      CFT_PENDING: if (fault_ack_i) w_state_nxt = CFT_IDLE;
      default:     w_state_nxt = CFT_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = CFT_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= CFT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc        <= '0;
      r_auth_reg   <= '0;
      r_fault_addr <= '0;
    end else if (flush_i) begin
      r_acc <= '0;
    end else begin
      // A start seen outside IDLE is not sampled, so a stray start in
      // ACCESS keeps the original authorising register and accumulator.
      if (r_state == CFT_IDLE && access_start_i) begin
        r_auth_reg <= auth_reg_i;
      end
      if (w_rsp) begin
        r_acc <= w_acc_upd;
        // Only the first faulting response records the address.
        if (r_acc == '0 && w_exc_eff != '0) begin
          r_fault_addr <= addr_i + (w_upper_fault ? 32'd2 : 32'd0);
        end
      end
      if (r_state == CFT_PENDING && fault_ack_i) begin
        r_acc <= '0;
      end
    end
  end

  ibex_cheri_cause_enc u_cause_enc (
    .exc_i   (r_acc),
    .cause_o (w_cause)
  );

  assign w_pending      = (r_state == CFT_PENDING);
  assign access_ready_o = !w_pending;
  assign fault_valid_o  = w_pending;
  assign fault_cause_o  = w_pending ? w_cause : 5'd0;
  assign fault_reg_o    = w_pending ? {1'b0, r_auth_reg} : 6'd0;
  assign fault_addr_o   = w_pending ? r_fault_addr : 32'd0;

`ifdef CHERI_FAULT_COUNT_EN
  logic [15:0] r_fault_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fault_count <= '0;
    end else if (r_state == CFT_ACCESS && w_state_nxt == CFT_PENDING &&
                 r_fault_count != 16'hFFFF) begin
      r_fault_count <= r_fault_count + 16'd1;
    end
  end

  assign fault_count_o = r_fault_count;
`endif

endmodule
